// File: rtl/serial_peer_port.sv
// serial_peer_port: far-end responder rebuilding words from the master's tx link and shifting words back on its rx link
// Optional SERIAL_PEER_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronisers.
module serial_peer_port #(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_in,
  input  logic sdi,
  input  logic latch_in,
  output logic [2**DATA_WIDTH_BASE-1:0] rx_data,
  output logic rx_valid,
  output logic frame_err,
  input  logic sck_rd,
  output logic sdo,
  input  logic [2**DATA_WIDTH_BASE-1:0] tx_data,
  input  logic tx_load,
  output logic tx_ready,
  output logic tx_done,
  output logic tx_underrun
);
  localparam int W = 2**DATA_WIDTH_BASE;
  localparam int CW = DATA_WIDTH_BASE + 1;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][3:0] sy;
  logic [3:0] cur, sync_q, sync_qq, rise, fall;
  logic [W-1:0] rx_sh, rx_sh_n, tx_sh;
  logic [CW-1:0] rx_cnt, rx_cnt_n, tx_cnt;
  logic done_n, under_n, last_rise;
  // lane order: 0 sck_in, 1 sdi, 2 latch_in, 3 sck_rd
  always_ff @(posedge clk)
    if (!rst) begin
      sy <= '0;
      sync_q <= '0;
      sync_qq <= '0;
    end else begin
      sy <= {sy[SYNC_STAGES-2:0], sck_rd, latch_in, sdi, sck_in};
      sync_q <= cur;
      sync_qq <= sync_q;
    end
`ifdef SERIAL_PEER_GLITCH_FILTER_EN
  logic [3:0] f0, f1, f2;
  always_ff @(posedge clk)
    if (!rst) begin
      f0 <= '0;
      f1 <= '0;
      f2 <= '0;
    end else begin
      f0 <= sy[SYNC_STAGES-1];
      f1 <= f0;
      f2 <= f1;
    end
  assign cur = (f0 & f1) | (f0 & f2) | (f1 & f2);
`else
  assign cur = sy[SYNC_STAGES-1];
`endif
  assign rise = sync_q & ~sync_qq;
  assign fall = ~sync_q & sync_qq;
  // a same-cycle sck rise is folded in before the latch is judged
  assign rx_sh_n = rise[0] ? {rx_sh[W-2:0], sync_q[1]} : rx_sh;
  assign rx_cnt_n = (rise[0] && rx_cnt != CW'(W + 1)) ? rx_cnt + 1'b1 : rx_cnt;
  always_ff @(posedge clk)
    if (!rst) begin
      rx_data <= '0;
      rx_sh <= '0;
      rx_cnt <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sh <= rx_sh_n;
      rx_cnt <= rise[2] ? '0 : rx_cnt_n;
      rx_valid <= rise[2] && rx_cnt_n == CW'(W);
      frame_err <= rise[2] && rx_cnt_n != CW'(W);
      if (rise[2] && rx_cnt_n == CW'(W)) rx_data <= rx_sh_n;
    end
  assign tx_ready = state == IDLE;
  assign last_rise = state == SHIFT && rise[3] && tx_cnt == CW'(W - 1);
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    under_n = 1'b0;
    state_n = (state == IDLE && tx_load) ? ARMED :
              (state == ARMED && rise[3]) ? SHIFT :
              last_rise ? IDLE : state;
    done_n = last_rise;
    under_n = state == IDLE && rise[3];
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      tx_sh <= '0;
      tx_cnt <= '0;
      sdo <= 1'b0;
      tx_done <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= state_n;
      tx_done <= done_n;
      tx_underrun <= under_n;
      if (state == IDLE && tx_load) begin
        tx_sh <= tx_data;
        sdo <= tx_data[W-1];
        tx_cnt <= '0;
      end else if (state == IDLE && rise[3]) sdo <= 1'b0;
      if (state != IDLE && rise[3]) tx_cnt <= tx_cnt + 1'b1;
      // sdo always mirrors tx_sh MSB, so a fall exposes the next bit
      if (state == SHIFT && fall[3]) begin
        tx_sh <= tx_sh << 1;
        sdo <= tx_sh[W-2];
      end
    end
endmodule

// File: tb/tb_serial_peer_port.sv
// tb_serial_peer_port: directed bench playing the serial master against serial_peer_port
module tb_serial_peer_port;
  localparam int W = 32;
  logic clk = 0, rst = 0, sck_in = 0, sdi = 0, latch_in = 0, sck_rd = 0, tx_load = 0;
  logic [W-1:0] tx_data = '0, rx_data;
  logic rx_valid, frame_err, sdo, tx_ready, tx_done, tx_underrun;
  int n_checks = 0, n_fail = 0;
  int c_valid = 0, c_ferr = 0, c_done = 0, c_under = 0;

  serial_peer_port dut (
    .clk(clk), .rst(rst), .sck_in(sck_in), .sdi(sdi), .latch_in(latch_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .sck_rd(sck_rd), .sdo(sdo), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // pulse counters: a stuck-high pulse shows up as a count above one
  always @(negedge clk) begin
    if (rx_valid === 1'b1) c_valid++;
    if (frame_err === 1'b1) c_ferr++;
    if (tx_done === 1'b1) c_done++;
    if (tx_underrun === 1'b1) c_under++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [W:0] w, input int n, input bit glitch);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = w[i];
      if (glitch && i == n / 2) begin
        wait_clk(4);
        sck_in = 1;
        wait_clk(1);
        sck_in = 0;
        wait_clk(3);
      end else wait_clk(8);
      sck_in = 1;
      wait_clk(8);
      sck_in = 0;
    end
  endtask

  task automatic latch();
    wait_clk(8);
    latch_in = 1;
    wait_clk(8);
    latch_in = 0;
    wait_clk(8);
  endtask

  task automatic recv(output logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      wait_clk(8);
      w[i] = sdo;
      sck_rd = 1;
      wait_clk(8);
      sck_rd = 0;
    end
    wait_clk(8);
  endtask

  task automatic load(input logic [W-1:0] d);
    tx_data = d;
    tx_load = 1;
    wait_clk(1);
    tx_load = 0;
    wait_clk(1);
  endtask

  task automatic test_reset();
    rst = 0;
    wait_clk(3);
    n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got %b want 0", sdo); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
    n_checks++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_tx_underrun got %b want 0", tx_underrun); end
    rst = 1;
    wait_clk(2);
  endtask

  task automatic test_rx_word();
    int v, f;
    v = c_valid; f = c_ferr;
    send_bits({1'b0, 32'hA5A5_0F0F}, 32, 0);
    latch();
    n_checks++; if (c_valid - v !== 1) begin n_fail++; $display("FAIL rx_word_valid got %0d pulses want 1", c_valid - v); end
    n_checks++; if (c_ferr - f !== 0) begin n_fail++; $display("FAIL rx_word_ferr got %0d pulses want 0", c_ferr - f); end
    n_checks++; if (rx_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL rx_word_data got %h want a5a50f0f", rx_data); end
  endtask

  task automatic test_short_frame();
    int v, f;
    v = c_valid; f = c_ferr;
    send_bits({1'b0, 32'h7FFF_0000}, 31, 0);
    latch();
    n_checks++; if (c_ferr - f !== 1) begin n_fail++; $display("FAIL short_ferr got %0d pulses want 1", c_ferr - f); end
    n_checks++; if (c_valid - v !== 0) begin n_fail++; $display("FAIL short_valid got %0d pulses want 0", c_valid - v); end
    n_checks++; if (rx_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL short_hold got %h want a5a50f0f", rx_data); end
    v = c_valid;
    send_bits({1'b0, 32'h1234_5678}, 32, 0);
    latch();
    n_checks++; if (c_valid - v !== 1) begin n_fail++; $display("FAIL after_short_valid got %0d pulses want 1", c_valid - v); end
    n_checks++; if (rx_data !== 32'h1234_5678) begin n_fail++; $display("FAIL after_short_data got %h want 12345678", rx_data); end
  endtask

  task automatic test_boundaries();
    int v, f;
    v = c_valid; f = c_ferr;
    latch();
    n_checks++; if (c_ferr - f !== 1) begin n_fail++; $display("FAIL bare_latch_ferr got %0d pulses want 1", c_ferr - f); end
    f = c_ferr;
    send_bits(33'h1_DEAD_0001, 33, 0);
    latch();
    n_checks++; if (c_ferr - f !== 1) begin n_fail++; $display("FAIL long_ferr got %0d pulses want 1", c_ferr - f); end
    n_checks++; if (c_valid - v !== 0) begin n_fail++; $display("FAIL long_valid got %0d pulses want 0", c_valid - v); end
    n_checks++; if (rx_data !== 32'h1234_5678) begin n_fail++; $display("FAIL long_hold got %h want 12345678", rx_data); end
    send_bits({1'b0, 32'h0F0F_A5A5}, 32, 0);
    latch();
    n_checks++; if (rx_data !== 32'h0F0F_A5A5) begin n_fail++; $display("FAIL after_long_data got %h want 0f0fa5a5", rx_data); end
  endtask

  task automatic test_tx_word();
    int d;
    logic [W-1:0] got;
    d = c_done;
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle got %b want 1", tx_ready); end
    load(32'hDEAD_BEEF);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_armed got %b want 0", tx_ready); end
    n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL tx_msb got %b want 1", sdo); end
    recv(got);
    n_checks++; if (got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tx_word got %h want deadbeef", got); end
    n_checks++; if (c_done - d !== 1) begin n_fail++; $display("FAIL tx_done got %0d pulses want 1", c_done - d); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_after got %b want 1", tx_ready); end
    n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL tx_lsb_hold got %b want 1", sdo); end
  endtask

  task automatic test_underrun();
    int u, d;
    logic [W-1:0] got;
    u = c_under; d = c_done;
    wait_clk(8);
    sck_rd = 1;
    wait_clk(8);
    sck_rd = 0;
    wait_clk(8);
    n_checks++; if (c_under - u !== 1) begin n_fail++; $display("FAIL underrun got %0d pulses want 1", c_under - u); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL underrun_sdo got %b want 0", sdo); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL underrun_ready got %b want 1", tx_ready); end
    load(32'h3C3C_5A5A);
    load(32'hFFFF_FFFF);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", tx_ready); end
    recv(got);
    n_checks++; if (got !== 32'h3C3C_5A5A) begin n_fail++; $display("FAIL ignored_load got %h want 3c3c5a5a", got); end
    n_checks++; if (c_done - d !== 1) begin n_fail++; $display("FAIL ignored_load_done got %0d pulses want 1", c_done - d); end
  endtask

  task automatic test_full_duplex();
    int v, d;
    logic [W-1:0] got;
    v = c_valid; d = c_done;
    load(32'h0BAD_C0DE);
    fork
      send_bits({1'b0, 32'hCAFE_F00D}, 32, 0);
      recv(got);
    join
    latch();
    n_checks++; if (rx_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL duplex_rx got %h want cafef00d", rx_data); end
    n_checks++; if (got !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL duplex_tx got %h want 0badc0de", got); end
    n_checks++; if (c_valid - v !== 1) begin n_fail++; $display("FAIL duplex_valid got %0d pulses want 1", c_valid - v); end
    n_checks++; if (c_done - d !== 1) begin n_fail++; $display("FAIL duplex_done got %0d pulses want 1", c_done - d); end
  endtask

  task automatic test_reset_mid_word();
    int v, f, d, u;
    logic [W-1:0] got;
    load(32'h7654_3210);
    fork
      send_bits({1'b0, 32'hFFFF_FFFF}, 16, 0);
      for (int i = 0; i < 16; i++) begin
        wait_clk(8);
        sck_rd = 1;
        wait_clk(8);
        sck_rd = 0;
      end
    join
    v = c_valid; f = c_ferr; d = c_done; u = c_under;
    rst = 0;
    wait_clk(3);
    n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL mid_reset_rx_data got %h want 0", rx_data); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sdo got %b want 0", sdo); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b want 1", tx_ready); end
    rst = 1;
    wait_clk(8);
    n_checks++; if (c_valid + c_ferr + c_done + c_under - v - f - d - u !== 0) begin n_fail++; $display("FAIL mid_reset_pulses got %0d pulses want 0", c_valid + c_ferr + c_done + c_under - v - f - d - u); end
    v = c_valid; f = c_ferr;
    load(32'h1357_9BDF);
    fork
      send_bits({1'b0, 32'h5555_AAAA}, 32, 0);
      recv(got);
    join
    latch();
    n_checks++; if (rx_data !== 32'h5555_AAAA) begin n_fail++; $display("FAIL post_reset_rx got %h want 5555aaaa", rx_data); end
    n_checks++; if (got !== 32'h1357_9BDF) begin n_fail++; $display("FAIL post_reset_tx got %h want 13579bdf", got); end
    n_checks++; if (c_valid - v !== 1 || c_ferr - f !== 0) begin n_fail++; $display("FAIL post_reset_pulses got valid %0d ferr %0d want 1 0", c_valid - v, c_ferr - f); end
  endtask

`ifdef SERIAL_PEER_GLITCH_FILTER_EN
  task automatic test_glitch();
    int v, f;
    v = c_valid; f = c_ferr;
    send_bits({1'b0, 32'hC3C3_3C3C}, 32, 1);
    latch();
    n_checks++; if (rx_data !== 32'hC3C3_3C3C) begin n_fail++; $display("FAIL glitch_data got %h want c3c33c3c", rx_data); end
    n_checks++; if (c_ferr - f !== 0) begin n_fail++; $display("FAIL glitch_ferr got %0d pulses want 0", c_ferr - f); end
    n_checks++; if (c_valid - v !== 1) begin n_fail++; $display("FAIL glitch_valid got %0d pulses want 1", c_valid - v); end
  endtask
`endif

  initial begin
    wait_clk(1);
    test_reset();
    test_rx_word();
    test_short_frame();
    test_boundaries();
    test_tx_word();
    test_underrun();
    test_full_duplex();
    test_reset_mid_word();
`ifdef SERIAL_PEER_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
